// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Sequences a combinational, word-aligned instruction memory. It holds the
// program counter, drives the fetch address, and buffers fetched words in a
// 2-entry FIFO towards decode using a valid/ready handshake. Execute and the
// top level control it with redirect, halt and fault.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous, active-high; same effect as redirect to RESET_PC
//   imem_addr    out  byte fetch address (current PC)
//   imem_rd      in   instruction word returned combinationally for imem_addr
//   instr        out  instruction at queue head
//   instr_pc     out  byte address of instr
//   instr_valid  out  queue head valid (masked during a redirect cycle)
//   instr_ready  in   decode accepts instr this cycle
//   redirect     in   load redirect_pc (low two bits forced to 0), flush queue
//   redirect_pc  in   redirect target
//   halt         in   stop fetching after the current cycle (RUN only)
//   fault        out  sticky: fetch attempted at or beyond 4*DEPTH
//   halted       out  controller is in HALT or FAULT
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter int               WIDTH    = 64,
    parameter int               DEPTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             fault,
    output logic             halted
);

    // One past the last valid byte address.
    localparam logic [WIDTH-1:0] MEM_BYTES = WIDTH'(4 * DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] pc;
    } entry_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [1:0]       count_q, count_d;
    entry_t           head_q, head_d;   // oldest entry, presented to decode
    entry_t           tail_q, tail_d;   // second entry, valid only when count==2

    logic   pop;
    logic   push;
    logic   in_range;
    entry_t new_entry;

    // Only bits [WIDTH-1:2] of the redirect target are meaningful.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Redirect masks valid combinationally so no handshake completes while
    // the queue is being flushed.
    assign instr_valid = (count_q != 2'd0) & ~redirect;
    assign pop         = instr_valid & instr_ready;
    assign in_range    = (pc_q < MEM_BYTES);
    assign push        = ~redirect & (state_q == ST_RUN) & in_range &
                         ((count_q < 2'd2) | pop);
    assign new_entry   = '{data: imem_rd, pc: pc_q};

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one
        // unassigned; that is what keeps this block from inferring latches.
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (redirect) begin
            count_d = 2'd0;
            pc_d    = {redirect_pc[WIDTH-1:2], 2'b00};
            state_d = ST_RUN;
        end else begin
            // Queue update. pop implies count>=1; push with count==2
            // implies pop, so the FIFO never overflows.
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = new_entry;
                    else                 tail_d = new_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; shift the tail forward to keep order.
                    if (count_q == 2'd1) begin
                        head_d = new_entry;
                    end else begin
                        head_d = tail_q;
                        tail_d = new_entry;
                    end
                end
                default: ;
            endcase

            if (push) pc_d = pc_q + PC_STEP;

            // A halt coinciding with a push lets the push complete first.
            if (state_q == ST_RUN) begin
                if (halt)           state_d = ST_HALT;
                else if (!in_range) state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its _d value from before this edge, independent of order.
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            // NOTE: the queue storage is cleared on reset so instr/instr_pc
            // read zero afterwards; redirect only empties it via count.
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = head_q.data;
    assign instr_pc  = head_q.pc;
    assign fault     = (state_q == ST_FAULT);
    assign halted    = (state_q != ST_RUN);

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the CPU's combinational, word-aligned 64-bit instruction memory: holds the program counter, drives the fetch address, and buffers fetched words in a 2-entry queue towards decode with a valid/ready handshake. Sits between the instruction memory and the decode stage, and takes redirect, halt and fault control from execute and the top level. Covers stalls, branch redirects, halting and out-of-range fetches, so the memory itself stays a pure lookup.

## Interface
Parameters:
- WIDTH, 64, data and address width; instruction words and PC are WIDTH bits
- DEPTH, 64, number of instruction words in memory; valid byte addresses are 0 .. 4*DEPTH-4
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  WIDTH  byte address to instruction memory; equals current PC
- imem_rd  in  WIDTH  instruction word returned combinationally for imem_addr
- instr  out  WIDTH  instruction at queue head
- instr_pc  out  WIDTH  byte address of instr
- instr_valid  out  1  queue head holds a valid instruction
- instr_ready  in  1  decode accepts instr this cycle
- redirect  in  1  load redirect_pc into PC, flush the queue
- redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored and forced to 0
- halt  in  1  stop fetching after the current cycle
- fault  out  1  sticky; fetch attempted at or beyond 4*DEPTH
- halted  out  1  controller is in HALT or FAULT state

## Operation
- State machine, states RUN, HALT, FAULT:
  - RUN -> HALT when halt=1 and redirect=0.
  - RUN -> FAULT when PC >= 4*DEPTH and redirect=0.
  - HALT or FAULT -> RUN only on redirect=1. halt is ignored outside RUN.
- Fetch: in RUN with PC < 4*DEPTH, a push occurs when count<2, or when count==2 and a pop happens this cycle.
  - A push writes {imem_rd, PC} into the queue and sets PC <= PC+4 (WIDTH-bit wrap).
  - No push means PC holds.
- Queue: 2-entry FIFO. Pop = instr_valid & instr_ready. Simultaneous push and pop leaves count unchanged, and order is preserved.
- instr_valid = (count>0) & ~redirect. This is combinational masking, so no handshake completes in a redirect cycle.
- Redirect has top priority:
  - Queue count <= 0.
  - PC <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - State <= RUN; fault <= 0.
  - No push or pop that cycle.
- A halt arriving in the same cycle as a push: the push still completes, then the state becomes HALT. The queue keeps draining to decode in HALT and FAULT.
- fault = (state==FAULT); halted = (state!=RUN).
- Reset has the same effect as redirect to RESET_PC, and wins over every other input. It also applies mid-stream.

## Timing
- Reset values:
  - PC = RESET_PC, imem_addr = RESET_PC.
  - count = 0, instr_valid = 0.
  - instr = 0, instr_pc = 0 (queue storage cleared).
  - state = RUN, fault = 0, halted = 0.
- Latency from fetch to decode is 1 cycle: a word pushed at edge N is presented with instr_valid=1 after edge N.
- First valid instruction: the first cycle after reset deasserts, with instr_pc = RESET_PC.
- Throughput: 1 instruction/cycle with instr_ready held high.
- Backpressure:
  - With instr_ready=0, the queue fills in 2 cycles, then PC and imem_addr hold.
  - The cycle instr_ready returns, pop and push occur together.
- Redirect:
  - In the redirect cycle, instr_valid=0.
  - The next cycle has imem_addr = target, and the target word is valid one cycle after that.
  - Redirect-to-valid latency is 2 edges.
- halt at edge N: imem_addr is frozen from edge N, and halted=1 after edge N.
- Fault: raised on the edge where RUN sees PC >= 4*DEPTH. Entries already queued remain valid until consumed.

## Test plan
- Reset, ready=1, memory word k = k+100 -> instr_valid rises 1 cycle after reset, instr_pc = 0,4,8,... on consecutive cycles, instr = 100,101,102,...
- Hold ready=0 for 5 cycles from reset, then ready=1 -> count saturates at 2, imem_addr stops at 8, then 0,4,8,12 are delivered in order with no gap or duplicate.
- Redirect to 0x2B (ready=1) while the queue is full -> instr_valid=0 in the redirect cycle; next cycle imem_addr = 0x28; then instr_pc = 0x28, instr = word 10; stale entries never appear.
- Assert halt for one cycle at PC=12 -> PC frozen at 16, halted=1, queued words drain, instr_valid=0 after that; redirect to 0 -> fetch resumes from 0, halted=0.
- DEPTH=64, redirect to 248 -> words at 248 and 252 are delivered, then fault=1 and halted=1 with PC=256; no further valid instructions; redirect to 0 clears fault.
- Assert reset mid-stream with the queue full and the state HALT -> all outputs take reset values on the next edge, and fetch restarts at RESET_PC.
